// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 pass sequencer and its S-memory port mux.
package arc4_pkg;

    localparam int S_AW   = 8;
    localparam int S_DW   = 8;
    // One engine's S-port bundle: {wren, addr, wrdata}
    localparam int PORT_W = 1 + S_AW + S_DW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_REQ,
        ST_INIT_RUN,
        ST_KSA_REQ,
        ST_KSA_RUN,
        ST_PRGA_REQ,
        ST_PRGA_RUN
    } seq_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_PRGA
    } owner_e;

    // Packs one engine's S-port signals into the bundle layout used by the mux.
    function automatic logic [PORT_W-1:0] pack_port(input logic            wren,
                                                    input logic [S_AW-1:0] addr,
                                                    input logic [S_DW-1:0] wrdata);
        return {wren, addr, wrdata};
    endfunction

endpackage

// File: rtl/s_port_mux.sv
// Routes exactly one engine's S-port bundle to the shared single-port S memory.
// No owner means an all-zero port, so no stray write can ever reach S.
module s_port_mux
    import arc4_pkg::*;
(
    input  owner_e            owner,
    input  logic [PORT_W-1:0] init_port,
    input  logic [PORT_W-1:0] ksa_port,
    input  logic [PORT_W-1:0] prga_port,
    output logic [S_AW-1:0]   s_addr,
    output logic [S_DW-1:0]   s_wrdata,
    output logic              s_wren
);

    logic [PORT_W-1:0] sel;

    // Pick the owner's bundle; write enables are selected, never ORed.
    always_comb begin
        sel = '0;
        case (owner)
            OWN_INIT: sel = init_port;
            OWN_KSA:  sel = ksa_port;
            OWN_PRGA: sel = prga_port;
            default:  sel = '0;
        endcase
    end

    assign s_wren   = sel[PORT_W-1];
    assign s_addr   = sel[S_AW+S_DW-1:S_DW];
    assign s_wrdata = sel[S_DW-1:0];

endmodule

// File: rtl/arc4_seq.sv
// Sequencer for one ARC4 decrypt pass: runs init -> ksa -> prga through their
// en/rdy handshakes, owns the S-memory arbitration and holds the pass key.
//
// Handshake: an engine with rdy=1 is idle; a one-cycle en while rdy=1 starts
// it; the engine drops rdy after the start and raises it again when finished.
// A phase completes only after rdy has been seen low (armed) and then high.
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int KEY_W   = 24,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic             err,
    output logic             init_en,
    output logic             ksa_en,
    output logic             prga_en,
    input  logic             init_rdy,
    input  logic             ksa_rdy,
    input  logic             prga_rdy,
    output logic [KEY_W-1:0] ksa_key,
    input  logic [7:0]       init_addr,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       init_wrdata,
    input  logic [7:0]       ksa_wrdata,
    input  logic [7:0]       prga_wrdata,
    input  logic             init_wren,
    input  logic             ksa_wren,
    input  logic             prga_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    output logic [2:0]       state_dbg
);

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    seq_state_e  state;
    owner_e      owner;
    logic [15:0] cnt;
    logic        armed;
    logic        run_rdy;
    logic        run_done;
    logic        run_expire;

    // Ready flag of the engine whose RUN phase is active.
    always_comb begin
        run_rdy = 1'b0;
        case (state)
            ST_INIT_RUN: run_rdy = init_rdy;
            ST_KSA_RUN:  run_rdy = ksa_rdy;
            ST_PRGA_RUN: run_rdy = prga_rdy;
            default:     run_rdy = 1'b0;
        endcase
    end

    assign run_done   = armed && run_rdy;
    assign run_expire = (cnt + 16'd1) == TIMEOUT_C;

    // Start pulses are combinational so each lasts exactly the one REQ cycle
    // in which the engine reports ready.
    assign init_en   = (state == ST_INIT_REQ) && init_rdy;
    assign ksa_en    = (state == ST_KSA_REQ)  && ksa_rdy;
    assign prga_en   = (state == ST_PRGA_REQ) && prga_rdy;
    assign state_dbg = state;

    // Pass FSM: phase ordering, ownership hand-over, timeout abort and key latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            rdy     <= 1'b1;
            err     <= 1'b0;
            ksa_key <= '0;
            cnt     <= '0;
            armed   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_INIT_REQ;
                        owner   <= OWN_INIT;
                        ksa_key <= key;
                        err     <= 1'b0;
                        rdy     <= 1'b0;
                    end
                end
                ST_INIT_REQ: begin
                    if (init_rdy) begin
                        state <= ST_INIT_RUN;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end
                end
                ST_KSA_REQ: begin
                    if (ksa_rdy) begin
                        state <= ST_KSA_RUN;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end
                end
                ST_PRGA_REQ: begin
                    if (prga_rdy) begin
                        state <= ST_PRGA_RUN;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end
                end
                ST_INIT_RUN, ST_KSA_RUN, ST_PRGA_RUN: begin
                    cnt <= cnt + 16'd1;
                    if (!run_rdy) begin
                        armed <= 1'b1;
                    end
                    if (run_done) begin
                        case (state)
                            ST_INIT_RUN: begin
                                state <= ST_KSA_REQ;
                                owner <= OWN_KSA;
                            end
                            ST_KSA_RUN: begin
                                state <= ST_PRGA_REQ;
                                owner <= OWN_PRGA;
                            end
                            default: begin
                                state <= ST_IDLE;
                                owner <= OWN_NONE;
                                rdy   <= 1'b1;
                            end
                        endcase
                    end else if (run_expire) begin
                        // Abort the pass; the stuck engine is left as it is.
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                        err   <= 1'b1;
                        rdy   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    s_port_mux u_mux (
        .owner     (owner),
        .init_port (pack_port(init_wren, init_addr, init_wrdata)),
        .ksa_port  (pack_port(ksa_wren, ksa_addr, ksa_wrdata)),
        .prga_port (pack_port(prga_wren, prga_addr, prga_wrdata)),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren)
    );

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq with behavioural init/ksa/prga engine models.
module tb_arc4_seq;

    localparam int KEY_W = 24;
    localparam int EW    = 27;   // event word: {type[1:0], err, ksa_key}

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [KEY_W-1:0] key = '0;
    logic             rdy, err, init_en, ksa_en, prga_en;
    logic             init_rdy, ksa_rdy, prga_rdy;
    logic [KEY_W-1:0] ksa_key;
    logic [7:0]       init_addr = 8'hFF, ksa_addr = 8'h2A, prga_addr = 8'h77;
    logic [7:0]       init_wrdata = 8'h11, ksa_wrdata = 8'h05, prga_wrdata = 8'h99;
    logic             init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b0;
    logic [7:0]       s_addr, s_wrdata;
    logic             s_wren;
    logic [2:0]       state_dbg;

    // engine models
    logic [2:0] eng_en;
    logic [2:0] eng_rdy;
    int         eng_cnt [3];
    int         eng_n   [3];
    bit         eng_hang[3];

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic          prev_rdy = 1'b1;

    assign eng_en   = {prga_en, ksa_en, init_en};
    assign init_rdy = eng_rdy[0];
    assign ksa_rdy  = eng_rdy[1];
    assign prga_rdy = eng_rdy[2];

    arc4_seq #(.KEY_W(KEY_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .err(err),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .ksa_key(ksa_key),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // engine models: rdy drops after en, rises N cycles later unless hung
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rdy <= 3'b111;
            for (int i = 0; i < 3; i++) eng_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (eng_en[i]) begin
                    eng_rdy[i] <= 1'b0;
                    eng_cnt[i] <= eng_n[i];
                end else if (!eng_rdy[i] && !eng_hang[i]) begin
                    if (eng_cnt[i] <= 1) eng_rdy[i] <= 1'b1;
                    else eng_cnt[i] <= eng_cnt[i] - 1;
                end
            end
        end
    end

    function automatic logic [EW-1:0] mk(input logic [1:0] t, input logic e,
                                         input logic [KEY_W-1:0] k);
        return {t, e, k};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic mon_pop(input logic [EW-1:0] got);
        logic [EW-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL mon_unexpected got=%h exp=none", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL mon_event got=%h exp=%h", got, exp);
            end
        end
    endtask

    // monitor: every engine start pulse and every pass completion is an event
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy = 1'b1;
        end else begin
            if (init_en) mon_pop(mk(2'd0, err, ksa_key));
            if (ksa_en)  mon_pop(mk(2'd1, err, ksa_key));
            if (prga_en) mon_pop(mk(2'd2, err, ksa_key));
            if (rdy && !prev_rdy) mon_pop(mk(2'd3, err, ksa_key));
            prev_rdy = rdy;
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0:       return init_en;
            1:       return ksa_en;
            2:       return prga_en;
            default: return rdy;
        endcase
    endfunction

    // returns on the negedge where the selected signal is high
    task automatic wait_for(input int w, input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            if (sig(w)) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    task automatic push_pass(input logic [KEY_W-1:0] k);
        exp_q.push_back(mk(2'd0, 1'b0, k));
        exp_q.push_back(mk(2'd1, 1'b0, k));
        exp_q.push_back(mk(2'd2, 1'b0, k));
        exp_q.push_back(mk(2'd3, 1'b0, k));
    endtask

    // ends at the negedge of the cycle after acceptance
    task automatic start_pass(input logic [KEY_W-1:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    initial begin
        eng_n[0] = 3; eng_n[1] = 5; eng_n[2] = 4;
        for (int i = 0; i < 3; i++) eng_hang[i] = 1'b0;

        // reset values, with init_wren held high to prove s_wren is gated
        @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_err", err, 0);
        check("rst_en", {init_en, ksa_en, prga_en}, 0);
        check("rst_s_wren", s_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_ksa_key", ksa_key, 0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_idle", {rdy, init_en, ksa_en, prga_en, s_wren}, 5'b10000);
        end

        // normal pass with arbitration checks
        push_pass(24'h00033C);
        start_pass(24'h00033C);
        check("init_en_latency", init_en, 1);
        check("rdy_drop", rdy, 0);
        check("init_own_addr", s_addr, 8'hFF);
        wait_for(1, 100, "wait_ksa_en");
        check("ksa_req_addr", s_addr, 8'h2A);
        @(negedge clk);
        check("ksa_run_addr", s_addr, 8'h2A);
        check("ksa_run_wrdata", s_wrdata, 8'h05);
        check("ksa_run_wren", s_wren, 1);
        wait_for(3, 100, "wait_pass1_done");
        check("pass1_err", err, 0);
        check("pass1_key", ksa_key, 24'h00033C);
        prga_wren = 1'b1;
        @(negedge clk);
        check("idle_s_wren", s_wren, 0);
        check("idle_s_addr", s_addr, 0);
        prga_wren = 1'b0;

        // busy: en pulses mid-pass and key changes are ignored
        push_pass(24'h00033C);
        start_pass(24'h00033C);
        wait_for(0, 100, "busy_init_en");
        @(negedge clk);
        key = 24'hFFFFFF;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        wait_for(2, 100, "busy_prga_en");
        @(negedge clk);
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        wait_for(3, 100, "busy_done");
        check("busy_key_held", ksa_key, 24'h00033C);
        repeat (6) @(negedge clk);
        check("busy_single_pass", exp_q.size(), 0);

        // timeout in KSA: 16 RUN cycles then abort
        eng_hang[1] = 1'b1;
        exp_q.push_back(mk(2'd0, 1'b0, 24'hABCDEF));
        exp_q.push_back(mk(2'd1, 1'b0, 24'hABCDEF));
        exp_q.push_back(mk(2'd3, 1'b1, 24'hABCDEF));
        start_pass(24'hABCDEF);
        wait_for(1, 100, "to_ksa_en");
        repeat (16) @(negedge clk);
        check("to_rdy_before", rdy, 0);
        check("to_err_before", err, 0);
        @(negedge clk);
        check("to_rdy", rdy, 1);
        check("to_err", err, 1);
        check("to_s_wren", s_wren, 0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", err, 1);
        eng_hang[1] = 1'b0;

        // next accepted en clears err and runs a full pass
        push_pass(24'h5A5A5A);
        start_pass(24'h5A5A5A);
        check("err_cleared", err, 0);
        wait_for(3, 200, "recover_done");
        check("recover_err", err, 0);

        // reset during KSA_RUN
        exp_q.push_back(mk(2'd0, 1'b0, 24'h0A0B0C));
        exp_q.push_back(mk(2'd1, 1'b0, 24'h0A0B0C));
        start_pass(24'h0A0B0C);
        wait_for(1, 100, "mid_ksa_en");
        @(negedge clk);
        check("mid_s_wren_pre", s_wren, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_s_wren", s_wren, 0);
        check("mid_rst_key", ksa_key, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // fresh pass after the reset
        push_pass(24'h123456);
        start_pass(24'h123456);
        wait_for(3, 200, "fresh_done");
        check("fresh_key", ksa_key, 24'h123456);
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
